// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state type, grant index
// width, UART timing constant and the default done-timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } arb_state_e;

  localparam int CLKS_PER_BIT           = 217;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int GRANT_W                = 3;

  // Next requester index after idx, wrapping at num.
  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx,
                                                  input int num);
    if (int'(idx) >= num - 1) begin
      return '0;
    end
    return idx + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: the first asserted request at or
// after the pointer, scanning upward and wrapping at NUM_REQ.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] pointer,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               valid
);

  logic [7:0] req_ext;
  int         pos;

  assign req_ext = 8'(req);

  // Scan from the farthest offset down so the nearest one to the pointer wins.
  always_comb begin
    grant_idx = pointer;
    valid     = 1'b0;
    pos       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(pointer) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (req_ext[GRANT_W'(pos)]) begin
        grant_idx = GRANT_W'(pos);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte requesters, round-robin, with a
// launch-to-done timeout that aborts a stuck frame.
//
// state        | meaning
// ST_IDLE      | waiting for any request; winner's byte and index latched on exit
// ST_LAUNCH    | one-cycle start strobe to uart_tx, timeout counter cleared
// ST_WAIT_DONE | waiting for end-of-frame or timeout
// ST_ACK       | acknowledge the granted requester, advance round-robin pointer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [NUM_REQ*8-1:0] i_Byte,
  output logic [NUM_REQ-1:0]   o_Ack,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  output logic                 o_Busy,
  output logic [2:0]           o_Grant,
  output logic                 o_Err
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [GRANT_W-1:0] win_idx;
  logic               win_valid;
  logic [7:0]         win_byte;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (i_Req),
    .pointer   (ptr_q),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  always_comb begin
    win_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == GRANT_W'(k)) begin
        win_byte = i_Byte[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_byte_q <= 8'h00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_byte_q <= tx_byte_d;
      cnt_q     <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  // A done pulse in the timeout cycle takes priority, so no error is flagged.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_byte_d = tx_byte_q;
    cnt_d     = cnt_q;
    o_TX_DV   = 1'b0;
    o_Err     = 1'b0;
    o_Ack     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d   = win_idx;
          tx_byte_d = win_byte;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        o_TX_DV = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = ST_ACK;
        end else if (timeout_hit) begin
          o_Err   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (grant_q == GRANT_W'(k)) begin
            o_Ack[k] = 1'b1;
          end
        end
        ptr_d   = wrap_inc(grant_q, NUM_REQ);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_Busy    = (state_q != ST_IDLE);
  assign o_Grant   = grant_q;
  assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle-timeline reference model,
// uart_tx stub with configurable frame length, and directed scenarios.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*8-1:0] bytes;
  logic [N-1:0]   ack;
  logic           dv;
  logic [7:0]     tx_byte;
  logic           tx_done;
  logic           busy;
  logic [2:0]     grant;
  logic           err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_Clock   (clk),
    .i_Rst_n   (rst_n),
    .i_Req     (req),
    .i_Byte    (bytes),
    .o_Ack     (ack),
    .o_TX_DV   (dv),
    .o_TX_Byte (tx_byte),
    .i_TX_Done (tx_done),
    .o_Busy    (busy),
    .o_Grant   (grant),
    .o_Err     (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stub: frame ends stub_delay cycles after the strobe (0 = never).
  int         stub_delay = 8;
  int         stub_cnt   = 0;
  logic       force_done = 1'b0;
  logic [7:0] rx_q[$];

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dv && stub_delay > 0) stub_cnt = stub_delay;
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          tx_done = 1'b1;
          rx_q.push_back(tx_byte);
        end
      end
      if (force_done) begin
        tx_done    = 1'b1;
        force_done = 1'b0;
      end
    end
  end

  // Reference model: cycle numbers of launch / ack, winner by rotation from pointer.
  logic       m_busy   = 1'b0;
  logic       m_wait   = 1'b0;
  int         m_launch = -10;
  int         m_ack    = -10;
  int         m_grant  = 0;
  int         m_ptr    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       exp_err;
  logic [N-1:0] exp_ack;

  int dv_cnt = 0, err_cnt = 0;
  int ack_cnt[N];
  int last_dv_cyc = 0, last_err_cyc = 0, last_ack_cyc = 0;
  int dv_cyc_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_wait   = 1'b0;
      m_launch = -10;
      m_ack    = -10;
      m_grant  = 0;
      m_ptr    = 0;
      m_byte   = 8'h00;
    end else begin
      exp_err = m_wait && !tx_done && (cyc == m_launch + TMO);
      exp_ack = (cyc == m_ack) ? N'(1 << m_grant) : '0;
      chk("tx_dv",   32'(dv),      32'(cyc == m_launch));
      chk("err",     32'(err),     32'(exp_err));
      chk("ack",     32'(ack),     32'(exp_ack));
      chk("busy",    32'(busy),    32'(m_busy));
      chk("grant",   32'(grant),   32'(m_grant));
      chk("tx_byte", 32'(tx_byte), 32'(m_byte));
      if (dv) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        dv_cyc_q.push_back(cyc);
      end
      if (err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (ack != 0) begin
        last_ack_cyc = cyc;
        for (int k = 0; k < N; k++) if (ack[k]) ack_cnt[k]++;
      end
      if (!m_busy) begin
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (((req >> ((m_ptr + k) % N)) & 1) != 0) m_grant = (m_ptr + k) % N;
          end
          m_byte   = 8'(bytes >> (8 * m_grant));
          m_busy   = 1'b1;
          m_launch = cyc + 1;
        end
      end else if (cyc == m_launch) begin
        m_wait = 1'b1;
      end else if (m_wait) begin
        if (tx_done || cyc == m_launch + TMO) begin
          m_wait = 1'b0;
          m_ack  = cyc + 1;
        end
      end else if (cyc == m_ack) begin
        m_ptr  = (m_grant + 1) % N;
        m_busy = 1'b0;
      end
    end
  end

  int ack_order[$];

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Collect n acks; an acked requester drops its request unless kept.
  task automatic wait_acks(input int n, input logic [N-1:0] keep, input int budget);
    int got;
    int t;
    logic [N-1:0] dropm;
    got = 0;
    t   = 0;
    while (got < n && t < budget) begin
      dropm = '0;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (ack[k]) begin
          got++;
          ack_order.push_back(k);
          if (!keep[k]) dropm[k] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      req = req & ~dropm;
      t++;
    end
    chk("acks_within_budget", 32'(got), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    idle(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (i < ack_order.size()) ? 32'(ack_order[i]) : 32'hFFFF_FFFF;
  endfunction

  int         e0, a0;
  int         exp_k[5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_b[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    bytes = '0;
    idle(3);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_dv",      32'(dv),      32'h0);
    chk("rst_ack",     32'(ack),     32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_grant",   32'(grant),   32'h0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // single request
    rx_q.delete(); ack_order.delete();
    e0 = err_cnt; a0 = dv_cnt;
    bytes[7:0] = 8'h3F;
    req = 4'b0001;
    wait_acks(1, '0, 100);
    chk("single_rx",   rx_at(0), 32'h3F);
    chk("single_ack",  ack_at(0), 32'd0);
    chk("single_dv",   32'(dv_cnt - a0), 32'd1);
    chk("single_nerr", 32'(err_cnt - e0), 32'd0);
    idle(3);

    // contention from reset, requester 0 stays asserted for a second turn
    do_reset();
    rx_q.delete(); ack_order.delete(); dv_cyc_q.delete();
    bytes = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req   = 4'b1111;
    wait_acks(4, 4'b0001, 400);
    wait_acks(1, '0, 200);
    for (int i = 0; i < 5; i++) begin
      chk("contend_order", ack_at(i), 32'(exp_k[i]));
      chk("contend_rx",    rx_at(i),  32'(exp_b[i]));
    end
    chk("grant_to_grant", 32'(dv_cyc_q[1] - dv_cyc_q[0]), 32'd11);
    idle(3);

    // wrap fairness: serve 2 alone (pointer -> 3), then 3 and 0 together
    bytes[23:16] = 8'h22;
    req = 4'b0100;
    wait_acks(1, '0, 100);
    rx_q.delete(); ack_order.delete();
    bytes[31:24] = 8'h33;
    bytes[7:0]   = 8'h11;
    req = 4'b1001;
    wait_acks(2, '0, 200);
    chk("wrap_first",  ack_at(0), 32'd3);
    chk("wrap_second", ack_at(1), 32'd0);
    chk("wrap_rx0",    rx_at(0),  32'h33);
    chk("wrap_rx1",    rx_at(1),  32'h11);
    idle(2);

    // byte changed and request dropped while the frame is in flight
    rx_q.delete(); ack_order.delete();
    stub_delay = 20;
    bytes[7:0] = 8'h5A;
    req = 4'b0001;
    idle(5);
    bytes[7:0] = 8'hC3;
    req = '0;
    wait_acks(1, '0, 100);
    chk("latched_rx",  rx_at(0),  32'h5A);
    chk("dropped_ack", ack_at(0), 32'd0);
    idle(2);

    // timeout with done never arriving
    stub_delay = 0;
    e0 = err_cnt;
    bytes[15:8] = 8'h77;
    req = 4'b0010;
    wait_acks(1, '0, 200);
    chk("tmo_err_cnt",   32'(err_cnt - e0), 32'd1);
    chk("tmo_err_delay", 32'(last_err_cyc - last_dv_cyc), 32'd64);
    chk("tmo_ack_delay", 32'(last_ack_cyc - last_err_cyc), 32'd1);
    chk("tmo_idle",      32'(busy), 32'h0);
    idle(2);

    // done in the same cycle as the timeout: no error
    rx_q.delete();
    stub_delay = 64;
    e0 = err_cnt;
    bytes[15:8] = 8'h78;
    req = 4'b0010;
    wait_acks(1, '0, 200);
    chk("tie_no_err",   32'(err_cnt - e0), 32'd0);
    chk("tie_ack_time", 32'(last_ack_cyc - last_dv_cyc), 32'd65);
    chk("tie_rx",       rx_at(0), 32'h78);
    idle(2);

    // reset mid-frame; uart stub still finishes and its done lands in idle
    stub_delay = 30;
    bytes[23:16] = 8'h44;
    req = 4'b0100;
    a0 = ack_cnt[2];
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    32'(busy),    32'h0);
    chk("midrst_grant",   32'(grant),   32'h0);
    chk("midrst_tx_byte", 32'(tx_byte), 32'h0);
    chk("midrst_ack",     32'(ack),     32'h0);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(30);
    chk("midrst_no_ack", 32'(ack_cnt[2] - a0), 32'd0);
    rx_q.delete(); ack_order.delete();
    stub_delay = 8;
    bytes[7:0] = 8'h99;
    req = 4'b0001;
    wait_acks(1, '0, 100);
    chk("post_rst_rx",  rx_at(0),  32'h99);
    chk("post_rst_ack", ack_at(0), 32'd0);

    // stray done while idle
    idle(2);
    force_done = 1'b1;
    idle(4);
    chk("stray_idle", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
